// File: rtl/mcycle_ctrl_fsm.sv
// Multicycle MIPS-subset control FSM (Moore).
// Optional EXC_EN macro adds the two-cycle exception sequence.
module mcycle_ctrl_fsm #(
  parameter logic [1:0] EXC_VECTOR_SEL = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_wr,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       alu_out_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       epc_write,
  output logic       exc_cause,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_FETCH_WAIT, S_DECODE,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_ADDR, S_MEM_READ, S_MEM_WAIT, S_WB_MEM,
    S_MEM_WRITE, S_BRANCH, S_JUMP, S_EXC
  } state_t;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;

  state_t     cur, nxt;
  logic       is_load;
  logic       bad_funct;
  logic       funct_ok;
  logic [2:0] funct_op;

  always_comb begin
    funct_op = OP_NONE;
    case (funct)
      6'h20:   funct_op = OP_ADD;
      6'h22:   funct_op = OP_SUB;
      6'h24:   funct_op = OP_AND;
      default: funct_op = OP_NONE;
    endcase
  end

  assign funct_ok = (funct_op != OP_NONE);

  // opcode/funct are only looked at in DECODE and EXEC_R; later
  // decisions use these captured flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= S_RESET;
      is_load   <= 1'b0;
      bad_funct <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) is_load <= (opcode == 6'h23);
      if (cur == S_EXEC_R) bad_funct <= !funct_ok;
    end
  end

`ifdef EXC_EN
  logic phase;
  logic cause_q;
  logic unused_bits;

  assign unused_bits = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      phase <= (cur == S_EXC) && !phase;
      if (nxt == S_EXC && cur != S_EXC)
        cause_q <= (cur == S_EXEC_I) ||
                   (cur == S_EXEC_R && funct_ok);
    end
  end
`else
  logic       phase;
  logic       cause_q;
  logic [2:0] unused_bits;

  assign phase       = 1'b0;
  assign cause_q     = 1'b0;
  assign unused_bits = {overflow, EXC_VECTOR_SEL};
`endif

  always_comb begin
    nxt = cur;
    case (cur)
      S_RESET:      nxt = S_FETCH;
      S_FETCH:      nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h00:        nxt = S_EXEC_R;
          6'h08:        nxt = S_EXEC_I;
          6'h23, 6'h2B: nxt = S_MEM_ADDR;
          6'h04:        nxt = S_BRANCH;
          6'h02:        nxt = S_JUMP;
`ifdef EXC_EN
          default:      nxt = S_EXC;
`else
          default:      nxt = S_FETCH;
`endif
        endcase
      end
`ifdef EXC_EN
      S_EXEC_R:     nxt = (!funct_ok || overflow) ? S_EXC : S_WB_R;
      S_EXEC_I:     nxt = overflow ? S_EXC : S_WB_I;
      S_EXC:        nxt = phase ? S_FETCH : S_EXC;
`else
      S_EXEC_R:     nxt = S_WB_R;
      S_EXEC_I:     nxt = S_WB_I;
      S_EXC:        nxt = S_FETCH;
`endif
      S_MEM_ADDR:   nxt = is_load ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:   nxt = S_MEM_WAIT;
      S_MEM_WAIT:   nxt = S_WB_MEM;
      S_WB_R, S_WB_I, S_WB_MEM,
      S_MEM_WRITE, S_BRANCH, S_JUMP:
                    nxt = S_FETCH;
      default:      nxt = S_RESET;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_wr        = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = OP_NONE;
    alu_out_write = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    epc_write     = 1'b0;
    case (cur)
      S_FETCH: begin
        alu_src_b = 2'b01;
        alu_op    = OP_ADD;
        pc_write  = 1'b1;
      end
      S_FETCH_WAIT: ir_write = 1'b1;
      S_DECODE: begin
        alu_src_b     = 2'b11;
        alu_op        = OP_ADD;
        alu_out_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a     = 1'b1;
        alu_op        = funct_op;
        alu_out_write = funct_ok;
      end
      S_WB_R: begin
        reg_dst   = 1'b1;
        reg_write = !bad_funct;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b10;
        alu_op        = OP_ADD;
        alu_out_write = 1'b1;
      end
      S_WB_I:     reg_write = 1'b1;
      S_MEM_READ: i_or_d = 1'b1;
      S_MEM_WAIT: begin
        i_or_d    = 1'b1;
        mdr_write = 1'b1;
      end
      S_WB_MEM: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        i_or_d = 1'b1;
        mem_wr = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = OP_SUB;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
`ifdef EXC_EN
      S_EXC: begin
        if (phase) begin
          pc_source = EXC_VECTOR_SEL;
          pc_write  = 1'b1;
        end else begin
          alu_src_b = 2'b01;
          alu_op    = OP_SUB;
          epc_write = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign exc_cause = cause_q;
  assign state     = cur;

endmodule

// File: tb/tb_mcycle_ctrl_fsm.sv
// Random-stimulus bench for mcycle_ctrl_fsm against an
// instruction-level trace model.
module tb_mcycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       overflow;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_wr;
  logic       ir_write;
  logic       mdr_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       alu_out_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       epc_write;
  logic       exc_cause;
  logic [3:0] state;

  always #5 clk = ~clk;

  mcycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .funct(funct), .overflow(overflow),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_wr(mem_wr), .ir_write(ir_write),
    .mdr_write(mdr_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .alu_out_write(alu_out_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .epc_write(epc_write), .exc_cause(exc_cause),
    .state(state)
  );

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_wr;
    logic       ir_write;
    logic       mdr_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       alu_out_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       epc_write;
    logic       exc_cause;
  } outs_t;

  typedef struct {
    int    st;
    outs_t o;
  } step_t;

  outs_t act;
  always_comb
    act = {pc_write, pc_write_cond, pc_source, i_or_d,
           mem_wr, ir_write, mdr_write, alu_src_a,
           alu_src_b, alu_op, alu_out_write, reg_dst,
           mem_to_reg, reg_write, epc_write, exc_cause};

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  step_t      q[$];
  logic [5:0] cur_op, cur_fn;
  bit         cur_ovf;
  bit         cause_m;

  function automatic outs_t spec_outs(int st, bit ph,
                                      logic [5:0] fn, bit wr,
                                      bit cause);
    outs_t o = '0;
    o.exc_cause = cause;
    case (st)
      1: begin o.pc_write = 1; o.alu_src_b = 2'b01; o.alu_op = 3'b001; end
      2: o.ir_write = 1;
      3: begin o.alu_src_b = 2'b11; o.alu_op = 3'b001; o.alu_out_write = 1; end
      4: begin
        o.alu_src_a = 1;
        o.alu_op = (fn == 6'h20) ? 3'b001 :
                   (fn == 6'h22) ? 3'b010 :
                   (fn == 6'h24) ? 3'b011 : 3'b000;
        o.alu_out_write = (o.alu_op != 3'b000);
      end
      5: begin o.reg_dst = 1; o.reg_write = wr; end
      6, 8: begin
        o.alu_src_a = 1; o.alu_src_b = 2'b10;
        o.alu_op = 3'b001; o.alu_out_write = 1;
      end
      7: o.reg_write = 1;
      9: o.i_or_d = 1;
      10: begin o.i_or_d = 1; o.mdr_write = 1; end
      11: begin o.mem_to_reg = 1; o.reg_write = 1; end
      12: begin o.i_or_d = 1; o.mem_wr = 1; end
      13: begin
        o.alu_src_a = 1; o.alu_op = 3'b010;
        o.pc_source = 2'b01; o.pc_write_cond = 1;
      end
      14: begin o.pc_source = 2'b10; o.pc_write = 1; end
      15: begin
        if (ph) begin
          o.pc_source = 2'b11; o.pc_write = 1;
        end else begin
          o.alu_src_b = 2'b01; o.alu_op = 3'b010; o.epc_write = 1;
        end
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(int st, bit ph = 0, bit wr = 1);
    step_t s;
    s.st = st;
    s.o  = spec_outs(st, ph, cur_fn, wr, cause_m);
    q.push_back(s);
  endtask

  task automatic take_exc(bit c);
    cause_m = c;
    push(15, 0);
    push(15, 1);
  endtask

  // Expected per-cycle trace of one instruction, from FETCH up to
  // (not including) the next FETCH.
  task automatic plan();
    bit fn_ok;
    fn_ok = (cur_fn == 6'h20) || (cur_fn == 6'h22) ||
            (cur_fn == 6'h24);
    push(1); push(2); push(3);
    case (cur_op)
      6'h00: begin
        push(4);
`ifdef EXC_EN
        if (!fn_ok) take_exc(0);
        else if (cur_ovf) take_exc(1);
        else push(5, 0, 1);
`else
        push(5, 0, fn_ok);
`endif
      end
      6'h08: begin
        push(6);
`ifdef EXC_EN
        if (cur_ovf) take_exc(1);
        else push(7);
`else
        push(7);
`endif
      end
      6'h23: begin push(8); push(9); push(10); push(11); end
      6'h2B: begin push(8); push(12); end
      6'h04: push(13);
      6'h02: push(14);
      default: begin
`ifdef EXC_EN
        take_exc(0);
`endif
      end
    endcase
  endtask

  localparam int ND = 8;
  logic [5:0] d_op [ND] = '{6'h00, 6'h23, 6'h2B, 6'h04,
                            6'h02, 6'h23, 6'h08, 6'h3F};
  logic [5:0] d_fn [ND] = '{6'h22, 6'h00, 6'h00, 6'h00,
                            6'h00, 6'h00, 6'h00, 6'h00};
  bit         d_ov [ND] = '{0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    int    di;
    bit    rst_pend;
    bit    rst_at_wait;
    step_t s;
    logic [5:0] pick_op [7];
    logic [5:0] pick_fn [4];

    di = 0; rst_pend = 0; rst_at_wait = 0; cause_m = 0;
    reset = 1'b1; opcode = '0; funct = '0; overflow = 1'b0;
    cur_op = '0; cur_fn = '0; cur_ovf = 0;

    repeat (3) begin
      @(posedge clk); #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_outs", 32'(act), 32'd0);
    end
    reset = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (rst_pend) begin
        check("abort_state", 32'(state), 32'd0);
        check("abort_outs", 32'(act), 32'd0);
        q.delete();
        cause_m  = 0;
        reset    = 1'b0;
        rst_pend = 0;
        continue;
      end
      if (q.size() == 0) begin
        if (di < ND) begin
          cur_op = d_op[di]; cur_fn = d_fn[di]; cur_ovf = d_ov[di];
          if (di == 5) rst_at_wait = 1;
          di++;
        end else begin
          pick_op = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02,
                      6'($urandom)};
          pick_fn = '{6'h20, 6'h22, 6'h24, 6'($urandom)};
          cur_op  = pick_op[$urandom_range(0, 6)];
          cur_fn  = pick_fn[$urandom_range(0, 3)];
          cur_ovf = ($urandom_range(0, 3) == 0);
        end
        opcode = cur_op;
        funct  = cur_fn;
        plan();
      end
      s = q.pop_front();
      check($sformatf("state_op%02h", cur_op), 32'(state), 32'(s.st));
      check($sformatf("outs_st%0d", s.st), 32'(act), 32'(s.o));
      overflow = (s.st == 4 || s.st == 6) ? cur_ovf : 1'($urandom);
      if (s.st == 10 && rst_at_wait) begin
        rst_at_wait = 0;
        reset = 1'b1;
        rst_pend = 1;
      end else if (di >= ND && $urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        rst_pend = 1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
